// File: rtl/count_connected_feeder.sv
// Graph feeder for the connected-count core: buffers upstream graphs and answers
// every core request with exactly one slot, a fixed DATA_IN_LATENCY cycles later.
module count_connected_feeder #(
   parameter int unsigned EXTRA_DATA_WIDTH = 10,
   parameter int unsigned DATA_IN_LATENCY  = 4,
   parameter int unsigned FIFO_DEPTH       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          feedEnable,
   input  logic                          inValid,
   output logic                          inReady,
   input  logic [127:0]                  inGraph,
   input  logic [EXTRA_DATA_WIDTH-1:0]   inExtraData,
   input  logic                          request,
   output logic [127:0]                  graphIn,
   output logic                          graphInValid,
   output logic [EXTRA_DATA_WIDTH-1:0]   extraDataIn,
   output logic [$clog2(FIFO_DEPTH):0]   fillLevel,
   output logic [31:0]                   servedCount,
   output logic [31:0]                   bubbleCount
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned DW = 128 + EXTRA_DATA_WIDTH;
   localparam int unsigned L  = DATA_IN_LATENCY;
   localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

   logic [DW-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_fill;
   logic          r_alive;
   logic [31:0]   r_served;
   logic [31:0]   r_bubble;

   logic [DW-1:0] r_st_data   [L];
   logic          r_st_valid  [L];
   logic          r_st_bubble [L];

   logic          w_push;
   logic          w_pop;
   logic [DW-1:0] w_head;
   logic          w_last_valid;
   logic          w_last_bubble;

   // inReady stays low until the first edge after reset release
   always_comb begin
      inReady = r_alive & (r_fill != FULL_LVL);
      w_push  = inValid & inReady;
      w_pop   = request & feedEnable & (r_fill != '0);
      w_head  = r_mem[r_rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {inGraph, inExtraData};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
         r_alive  <= 1'b0;
      end else begin
         r_alive <= 1'b1;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

   // Data is zeroed on entry for non-valid slots, so outputs need no masking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < L; i++) begin
            r_st_data[i]   <= '0;
            r_st_valid[i]  <= 1'b0;
            r_st_bubble[i] <= 1'b0;
         end
      end else begin
         r_st_data[0]   <= w_pop ? w_head : '0;
         r_st_valid[0]  <= w_pop;
         r_st_bubble[0] <= request & ~w_pop;
         for (int unsigned i = 1; i < L; i++) begin
            r_st_data[i]   <= r_st_data[i-1];
            r_st_valid[i]  <= r_st_valid[i-1];
            r_st_bubble[i] <= r_st_bubble[i-1];
         end
      end
   end

   // Counters track the slot entering the last stage so they move with the outputs
   generate
      if (L == 1) begin : g_short
         always_comb begin
            w_last_valid  = w_pop;
            w_last_bubble = request & ~w_pop;
         end
      end else begin : g_long
         always_comb begin
            w_last_valid  = r_st_valid[L-2];
            w_last_bubble = r_st_bubble[L-2];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_served <= '0;
         r_bubble <= '0;
      end else begin
         if (w_last_valid) r_served <= r_served + 32'd1;
         if (w_last_bubble && (r_bubble != '1)) r_bubble <= r_bubble + 32'd1;
      end
   end

   always_comb begin
      graphIn      = r_st_data[L-1][DW-1:EXTRA_DATA_WIDTH];
      extraDataIn  = r_st_data[L-1][EXTRA_DATA_WIDTH-1:0];
      graphInValid = r_st_valid[L-1];
      fillLevel    = r_fill;
      servedCount  = r_served;
      bubbleCount  = r_bubble;
   end

endmodule

// File: tb/tb_count_connected_feeder.sv
// Bench for count_connected_feeder: three latency variants share one stimulus stream
// and are compared every cycle against a queue-based reference model.
module tb_count_connected_feeder;
   localparam int unsigned EW    = 10;
   localparam int unsigned DEPTH = 16;

   typedef struct packed {
      logic          v;
      logic          b;
      logic [127:0]  g;
      logic [EW-1:0] e;
   } slot_t;

   typedef struct {
      logic          iv;
      logic [127:0]  g;
      logic [EW-1:0] tag;
      logic          req;
      logic          fe;
      logic          ev;
      logic [127:0]  eg;
      logic [EW-1:0] etag;
      int            efill;
      int            eserved;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          feedEnable = 1'b0;
   logic          inValid = 1'b0;
   logic [127:0]  inGraph = '0;
   logic [EW-1:0] inExtraData = '0;
   logic          request = 1'b0;

   logic          o_ready [3];
   logic [127:0]  o_graph [3];
   logic          o_valid [3];
   logic [EW-1:0] o_extra [3];
   logic [4:0]    o_fill  [3];
   logic [31:0]   o_served[3];
   logic [31:0]   o_bubble[3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      count_connected_feeder #(
         .EXTRA_DATA_WIDTH(EW),
         .DATA_IN_LATENCY((k == 0) ? 4 : ((k == 1) ? 1 : 16)),
         .FIFO_DEPTH(DEPTH)
      ) u_dut (
         .clk         (clk),
         .rst         (rst_n),
         .feedEnable  (feedEnable),
         .inValid     (inValid),
         .inReady     (o_ready[k]),
         .inGraph     (inGraph),
         .inExtraData (inExtraData),
         .request     (request),
         .graphIn     (o_graph[k]),
         .graphInValid(o_valid[k]),
         .extraDataIn (o_extra[k]),
         .fillLevel   (o_fill[k]),
         .servedCount (o_served[k]),
         .bubbleCount (o_bubble[k])
      );
   end

   // Reference model: FIFO as a queue, latency as a queue of in-flight slots
   slot_t          pipe_q [3][$];
   logic [137:0]   fifo_q [3][$];
   slot_t          m_out    [3];
   logic [31:0]    m_served [3];
   logic [31:0]    m_bubble [3];
   bit             m_alive  [3];
   int             req_cnt  [3];
   bit             model_on = 1'b0;

   function automatic int lat(int k);
      return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
   endfunction

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         pipe_q[k].delete();
         fifo_q[k].delete();
         for (int i = 0; i < lat(k) - 1; i++) pipe_q[k].push_back('0);
         m_out[k]    = '0;
         m_served[k] = '0;
         m_bubble[k] = '0;
         m_alive[k]  = 1'b0;
         req_cnt[k]  = 0;
      end
   endtask

   task automatic model_step(int k);
      bit    push, pop;
      slot_t s;
      push = m_alive[k] && (fifo_q[k].size() < DEPTH) && inValid;
      pop  = request && feedEnable && (fifo_q[k].size() > 0);
      s = '0;
      if (pop) begin
         s.v = 1'b1;
         {s.g, s.e} = fifo_q[k].pop_front();
      end else if (request) begin
         s.b = 1'b1;
      end
      if (request) req_cnt[k]++;
      if (push) fifo_q[k].push_back({inGraph, inExtraData});
      pipe_q[k].push_back(s);
      m_out[k] = pipe_q[k].pop_front();
      if (m_out[k].v) m_served[k] = m_served[k] + 32'd1;
      if (m_out[k].b && m_bubble[k] != 32'hFFFF_FFFF) m_bubble[k] = m_bubble[k] + 32'd1;
      m_alive[k] = 1'b1;
   endtask

   task automatic model_cmp(int k);
      int L;
      L = lat(k);
      chk($sformatf("graph_L%0d", L),  o_graph[k],  m_out[k].g);
      chk($sformatf("valid_L%0d", L),  o_valid[k],  m_out[k].v);
      chk($sformatf("extra_L%0d", L),  o_extra[k],  m_out[k].e);
      chk($sformatf("fill_L%0d", L),   o_fill[k],   fifo_q[k].size());
      chk($sformatf("ready_L%0d", L),  o_ready[k],  m_alive[k] && fifo_q[k].size() < DEPTH);
      chk($sformatf("served_L%0d", L), o_served[k], m_served[k]);
      chk($sformatf("bubble_L%0d", L), o_bubble[k], m_bubble[k]);
   endtask

   always @(negedge rst_n) model_reset();

   always @(posedge clk) begin
      if (rst_n && model_on) begin
         for (int k = 0; k < 3; k++) model_step(k);
         #1;
         for (int k = 0; k < 3; k++) model_cmp(k);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic iv, logic [127:0] g, logic [EW-1:0] t, logic rq, logic fe);
      inValid     = iv;
      inGraph     = g;
      inExtraData = t;
      request     = rq;
      feedEnable  = fe;
   endtask

   task automatic idle(int n);
      drive(1'b0, '0, '0, 1'b0, feedEnable);
      repeat (n) tick();
   endtask

   vec_t tbl [8];

   initial begin
      model_reset();
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         chk("rst_valid", o_valid[k], 1'b0);
         chk("rst_ready", o_ready[k], 1'b0);
         chk("rst_fill", o_fill[k], 0);
      end
      model_on = 1'b1;
      rst_n = 1'b1;
      tick();
      chk("ready_after_release", o_ready[0], 1'b1);

      // Two graphs pushed, two requests, answers 4 cycles later in order
      tbl[0] = '{1'b1, 128'h1, 10'd5, 1'b0, 1'b0, 1'b0, '0,     '0,    1, 0};
      tbl[1] = '{1'b1, 128'h3, 10'd6, 1'b0, 1'b0, 1'b0, '0,     '0,    2, 0};
      tbl[2] = '{1'b0, '0,     '0,    1'b1, 1'b1, 1'b0, '0,     '0,    1, 0};
      tbl[3] = '{1'b0, '0,     '0,    1'b1, 1'b1, 1'b0, '0,     '0,    0, 0};
      tbl[4] = '{1'b0, '0,     '0,    1'b0, 1'b1, 1'b0, '0,     '0,    0, 0};
      tbl[5] = '{1'b0, '0,     '0,    1'b0, 1'b1, 1'b1, 128'h1, 10'd5, 0, 1};
      tbl[6] = '{1'b0, '0,     '0,    1'b0, 1'b1, 1'b1, 128'h3, 10'd6, 0, 2};
      tbl[7] = '{1'b0, '0,     '0,    1'b0, 1'b1, 1'b0, '0,     '0,    0, 2};
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].iv, tbl[i].g, tbl[i].tag, tbl[i].req, tbl[i].fe);
         tick();
         chk($sformatf("tbl%0d_valid", i),  o_valid[0],  tbl[i].ev);
         chk($sformatf("tbl%0d_graph", i),  o_graph[0],  tbl[i].eg);
         chk($sformatf("tbl%0d_extra", i),  o_extra[0],  tbl[i].etag);
         chk($sformatf("tbl%0d_fill", i),   o_fill[0],   tbl[i].efill);
         chk($sformatf("tbl%0d_served", i), o_served[0], tbl[i].eserved);
         chk($sformatf("tbl%0d_bubble", i), o_bubble[0], 0);
      end

      // Empty FIFO: three requests become three bubbles
      drive(1'b0, '0, '0, 1'b1, 1'b1);
      repeat (3) tick();
      idle(5);
      chk("empty_bubbles", o_bubble[0], 3);
      chk("empty_served", o_served[0], 2);

      // Fill to full; a 17th graph is refused, also on a pop cycle
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 128'(100 + i), 10'(i), 1'b0, 1'b1);
         tick();
      end
      chk("full_fill", o_fill[0], 16);
      chk("full_ready", o_ready[0], 1'b0);
      drive(1'b1, 128'd999, 10'd99, 1'b1, 1'b1);
      tick();
      chk("full_pop_fill", o_fill[0], 15);
      chk("full_pop_ready", o_ready[0], 1'b1);
      drive(1'b1, 128'd999, 10'd99, 1'b0, 1'b1);
      tick();
      chk("refill_fill", o_fill[0], 16);
      drive(1'b0, '0, '0, 1'b1, 1'b1);
      repeat (16) tick();
      idle(5);
      chk("drain_fill", o_fill[0], 0);
      chk("drain_served", o_served[0], 19);
      chk("drain_bubble", o_bubble[0], 3);

      // feedEnable=0 turns requests into bubbles without touching the FIFO
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 128'(200 + i), 10'(20 + i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      repeat (4) tick();
      chk("fe0_fill", o_fill[0], 4);
      drive(1'b0, '0, '0, 1'b1, 1'b1);
      repeat (4) tick();
      chk("fe1_first_valid", o_valid[0], 1'b1);
      chk("fe1_first_graph", o_graph[0], 128'd200);
      idle(5);
      chk("fe_served", o_served[0], 23);
      chk("fe_bubble", o_bubble[0], 7);

      // Asynchronous reset with slots in flight
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 128'(300 + i), 10'(30 + i), 1'b0, 1'b1);
         tick();
      end
      drive(1'b0, '0, '0, 1'b1, 1'b1);
      repeat (3) tick();
      chk("pre_rst_fill", o_fill[0], 5);
      #3 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("async_valid", o_valid[k], 1'b0);
         chk("async_graph", o_graph[k], '0);
         chk("async_fill", o_fill[k], 0);
         chk("async_served", o_served[k], 0);
         chk("async_bubble", o_bubble[k], 0);
         chk("async_ready", o_ready[k], 1'b0);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         for (int k = 0; k < 3; k++) chk("post_rst_no_graph", o_valid[k], 1'b0);
      end
      idle(2);

      // Random traffic; the model checks every cycle on all three latencies
      for (int i = 0; i < 10000; i++) begin
         drive($urandom_range(0, 9) < 6, {$urandom, $urandom, $urandom, $urandom},
               10'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 8);
         tick();
      end
      idle(20);
      for (int k = 0; k < 3; k++)
         chk($sformatf("served_plus_bubble_L%0d", lat(k)), o_served[k] + o_bubble[k], req_cnt[k]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
